// File: rtl/generic_rr_arbiter.sv
// Packet-aware round-robin arbiter: NUM_REQ valid/ready sources share one
// registered output stream; a winner keeps the grant until its last beat.
module generic_rr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int IDX_W      = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]            req_last_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   output logic                          out_valid_o,
   output logic [DATA_WIDTH-1:0]         out_data_o,
   output logic                          out_last_o,
   output logic [IDX_W-1:0]              out_src_o,
   input  logic                          out_ready_i,
   output logic                          busy_o
);

   typedef enum logic {
      IDLE,
      LOCKED
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic [IDX_W-1:0]      owner_q;
   logic [IDX_W-1:0]      owner_d;
   logic [IDX_W-1:0]      ptr_q;
   logic [IDX_W-1:0]      ptr_d;
   logic [IDX_W-1:0]      hi_idx;
   logic [IDX_W-1:0]      lo_idx;
   logic                  hi_found;
   logic                  lo_found;
   logic [IDX_W-1:0]      win;
   logic                  win_vld;
   logic                  win_last;
   logic [DATA_WIDTH-1:0] win_data;
   logic                  slot_free;
   logic                  accept;

   // Descending scan so the lowest qualifying index is the one left standing
   always_comb begin
      hi_idx   = '0;
      lo_idx   = '0;
      hi_found = 1'b0;
      lo_found = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid_i[i]) begin
            lo_idx   = IDX_W'(i);
            lo_found = 1'b1;
            if (IDX_W'(i) >= ptr_q) begin
               hi_idx   = IDX_W'(i);
               hi_found = 1'b1;
            end
         end
      end
   end

   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      if (state_q == LOCKED) begin
         win     = owner_q;
         win_vld = req_valid_i[owner_q];
      end else begin
         win     = hi_found ? hi_idx : lo_idx;
         win_vld = lo_found;
      end
   end

   always_comb begin
      win_data = '0;
      win_last = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win == IDX_W'(i)) begin
            win_data = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            win_last = req_last_i[i];
         end
      end
   end

   assign slot_free = !out_valid_o || out_ready_i;
   assign accept    = slot_free && win_vld;

   always_comb begin
      req_ready_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready_o[i] = reset_n && accept && (win == IDX_W'(i));
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      if (accept) begin
         if (win_last) begin
            state_d = IDLE;
            // Explicit wrap keeps non-power-of-2 counts correct
            if (win == IDX_W'(NUM_REQ - 1)) begin
               ptr_d = '0;
            end else begin
               ptr_d = win + 1'b1;
            end
         end else begin
            state_d = LOCKED;
            owner_d = win;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_o <= 1'b0;
         out_data_o  <= '0;
         out_last_o  <= 1'b0;
         out_src_o   <= '0;
      end else if (accept) begin
         out_valid_o <= 1'b1;
         out_data_o  <= win_data;
         out_last_o  <= win_last;
         out_src_o   <= win;
      end else if (out_ready_i) begin
         out_valid_o <= 1'b0;
      end
   end

   assign busy_o = (state_q == LOCKED);

endmodule

// File: tb/tb_generic_rr_arbiter.sv
// Bench for generic_rr_arbiter: rotating-search reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_generic_rr_arbiter;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int IW = 2;

   logic             clk       = 1'b0;
   logic             reset_n   = 1'b0;
   logic [N-1:0]     req_valid = '0;
   logic [N-1:0]     req_last  = '0;
   logic [N-1:0]     req_ready;
   logic [W-1:0]     d [N];
   logic [N*W-1:0]   req_data;
   logic             out_valid;
   logic [W-1:0]     out_data;
   logic             out_last;
   logic [IW-1:0]    out_src;
   logic             out_ready = 1'b1;
   logic             busy;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign req_data[g*W +: W] = d[g];
   end

   generic_rr_arbiter #(
      .NUM_REQ    (N),
      .DATA_WIDTH (W),
      .IDX_W      (IW)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_valid_i (req_valid),
      .req_data_i  (req_data),
      .req_last_i  (req_last),
      .req_ready_o (req_ready),
      .out_valid_o (out_valid),
      .out_data_o  (out_data),
      .out_last_o  (out_last),
      .out_src_o   (out_src),
      .out_ready_i (out_ready),
      .busy_o      (busy)
   );

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                  $time);
      end
   endtask

   // Reference model: packet lock flag, owner, pointer, output register
   bit           m_locked;
   int           m_owner;
   int           m_ptr;
   bit           m_ov;
   bit           m_ol;
   logic [W-1:0] m_od;
   int           m_os;
   bit           e_found;
   bit           e_acc;
   int           e_win;
   logic [N-1:0] e_ready;

   task automatic m_eval();
      e_found = 1'b0;
      e_win   = 0;
      if (m_locked) begin
         e_win   = m_owner;
         e_found = req_valid[m_owner];
      end else begin
         for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (!e_found && req_valid[idx]) begin
               e_found = 1'b1;
               e_win   = idx;
            end
         end
      end
      e_acc   = (!m_ov || out_ready) && e_found;
      e_ready = e_acc ? (N'(1) << e_win) : '0;
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            m_locked = 1'b0;
            m_owner  = 0;
            m_ptr    = 0;
            m_ov     = 1'b0;
            m_ol     = 1'b0;
            m_od     = '0;
            m_os     = 0;
         end else begin
            m_eval();
            if (e_acc) begin
               m_ov = 1'b1;
               m_od = d[e_win];
               m_ol = req_last[e_win];
               m_os = e_win;
               if (req_last[e_win]) begin
                  m_locked = 1'b0;
                  m_ptr    = (e_win + 1) % N;
               end else begin
                  m_locked = 1'b1;
                  m_owner  = e_win;
               end
            end else if (out_ready) begin
               m_ov = 1'b0;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (reset_n) begin
            m_eval();
            chk("m_ready", req_ready, e_ready);
            chk("m_busy", busy, m_locked);
            chk("m_valid", out_valid, m_ov);
            chk("m_data", out_data, m_od);
            chk("m_last", out_last, m_ol);
            chk("m_src", out_src, m_os);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      @(negedge clk);
   endtask

   int exp_seq [7] = '{0, 1, 2, 3, 0, 1, 2};

   initial begin
      foreach (d[i]) d[i] = '0;

      // Reset held with random inputs
      for (int c = 0; c < 3; c++) begin
         tick();
         req_valid = N'($urandom);
         req_last  = N'($urandom);
         out_ready = 1'($urandom);
         foreach (d[i]) d[i] = $urandom;
         look();
         chk("rst_ready", req_ready, 0);
         chk("rst_valid", out_valid, 0);
         chk("rst_busy", busy, 0);
      end
      chk("rst_data", out_data, 0);
      chk("rst_last", out_last, 0);
      chk("rst_src", out_src, 0);

      tick();
      req_valid = '0;
      req_last  = '0;
      out_ready = 1'b1;
      reset_n   = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         look();
         chk("idle_valid", out_valid, 0);
      end

      // All requesters, single-beat packets
      tick();
      req_valid = 4'hF;
      req_last  = 4'hF;
      foreach (d[i]) d[i] = 32'h100 + i;
      for (int i = 0; i < 7; i++) begin
         tick();
         if (i == 6) req_valid = '0;
         look();
         chk("rr_src", out_src, exp_seq[i]);
         chk("rr_data", out_data, 32'h100 + exp_seq[i]);
      end
      tick();
      tick();

      // Requester 1 three-beat packet while 0 waits
      req_valid = 4'b0010;
      req_last  = 4'b0000;
      d[1]      = 32'hA1;
      tick();
      req_valid = 4'b0011;
      req_last  = 4'b0001;
      d[0]      = 32'hB0;
      d[1]      = 32'hA2;
      look();
      chk("pk_src1", out_src, 1);
      chk("pk_data1", out_data, 32'hA1);
      chk("pk_busy1", busy, 1);
      chk("pk_ready1", req_ready, 4'b0010);
      tick();
      req_last = 4'b0011;
      d[1]     = 32'hA3;
      look();
      chk("pk_data2", out_data, 32'hA2);
      chk("pk_last2", out_last, 0);
      chk("pk_busy2", busy, 1);
      tick();
      req_valid = 4'b0001;
      look();
      chk("pk_data3", out_data, 32'hA3);
      chk("pk_last3", out_last, 1);
      chk("pk_busy3", busy, 0);
      tick();
      req_valid = '0;
      look();
      chk("pk_src4", out_src, 0);
      chk("pk_data4", out_data, 32'hB0);
      tick();
      tick();

      // Downstream stall
      req_valid = 4'b0100;
      req_last  = 4'b0100;
      d[2]      = 32'hC0;
      tick();
      out_ready = 1'b0;
      d[2]      = 32'hC1;
      for (int c = 0; c < 3; c++) begin
         look();
         chk("st_data", out_data, 32'hC0);
         chk("st_src", out_src, 2);
         chk("st_ready", req_ready, 0);
         tick();
      end
      out_ready = 1'b1;
      look();
      chk("st_release", req_ready, 4'b0100);
      tick();
      req_valid = '0;
      look();
      chk("st_data2", out_data, 32'hC1);
      tick();
      tick();

      // Owner bubble mid-packet while 3 waits
      req_valid = 4'b0100;
      req_last  = 4'b0000;
      d[2]      = 32'hD0;
      tick();
      req_valid = 4'b1000;
      req_last  = 4'b1000;
      d[3]      = 32'hE0;
      look();
      chk("gap_data0", out_data, 32'hD0);
      chk("gap_ready0", req_ready, 0);
      tick();
      look();
      chk("gap_valid1", out_valid, 0);
      chk("gap_busy1", busy, 1);
      tick();
      req_valid = 4'b1100;
      req_last  = 4'b1100;
      d[2]      = 32'hD1;
      look();
      chk("gap_valid2", out_valid, 0);
      chk("gap_ready2", req_ready, 4'b0100);
      tick();
      req_valid = 4'b1000;
      look();
      chk("gap_data3", out_data, 32'hD1);
      chk("gap_src3", out_src, 2);
      tick();
      req_valid = '0;
      look();
      chk("gap_src4", out_src, 3);
      chk("gap_data4", out_data, 32'hE0);
      tick();
      tick();

      // Reset mid-packet clears the pointer too
      req_valid = 4'b0010;
      req_last  = 4'b0010;
      d[1]      = 32'hF0;
      tick();
      req_last = 4'b0000;
      d[1]     = 32'hF1;
      tick();
      look();
      chk("mr_busy", busy, 1);
      #1;
      reset_n = 1'b0;
      #1;
      chk("mr_busy0", busy, 0);
      chk("mr_valid0", out_valid, 0);
      chk("mr_ready0", req_ready, 0);
      tick();
      reset_n   = 1'b1;
      req_valid = 4'b1010;
      req_last  = 4'b1010;
      d[1]      = 32'h51;
      d[3]      = 32'h53;
      tick();
      look();
      chk("mr_src", out_src, 1);
      chk("mr_data", out_data, 32'h51);
      tick();
      req_valid = '0;
      look();
      chk("mr_src2", out_src, 3);
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/generic_rr_arbiter.md
# generic_rr_arbiter

Packet-aware round-robin arbiter that shares one registered output channel between NUM_REQ valid/ready requesters. Each cycle it selects the first requester at or above a rotating priority pointer (find-first-set with wrap). It then holds the grant until the selected requester's last beat is accepted. The block sits in front of shared debug/trace sinks wherever several sources feed a single stream.

## Interface
- NUM_REQ, 4: number of requesters, ≥2, any value (need not be a power of 2).
- DATA_WIDTH, 32: beat payload width.
- IDX_W, max($clog2(NUM_REQ),1): width of the source index.
- clk  in  1  single clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid_i  in  NUM_REQ  per-requester beat valid.
- req_data_i  in  NUM_REQ×DATA_WIDTH  per-requester beat payload.
- req_last_i  in  NUM_REQ  final beat of the packet.
- req_ready_o  out  NUM_REQ  beat accepted from requester i this cycle; at most one bit high.
- out_valid_o  out  1  output register holds a beat.
- out_data_o  out  DATA_WIDTH  registered payload.
- out_last_o  out  1  registered last flag.
- out_src_o  out  IDX_W  index of the requester that supplied the beat.
- out_ready_i  in  1  downstream accepts the beat.
- busy_o  out  1  high in state LOCKED.

## Operation
- State: state ∈ {IDLE, LOCKED}, owner[IDX_W], rr_ptr[IDX_W], and the output register.
- Slot free: slot_free = !out_valid_o | out_ready_i.
- Winner in IDLE: first set bit of req_valid_i & (mask of indices ≥ rr_ptr). If none, first set bit of req_valid_i, scanning from 0 upward.
- Winner in LOCKED: owner only. No other requester is considered.
- Accept rule: req_ready_o[w] = slot_free & req_valid_i[w], where w is the winner; all other bits are 0.
- Fairness is packet-granular: once a requester wins, it keeps the grant until its last beat is accepted.
- Beat accepted, req_last_i[w]=0: state←LOCKED, owner←w.
- Beat accepted, req_last_i[w]=1: state←IDLE, rr_ptr←(w+1) mod NUM_REQ. Wrap uses an explicit compare against NUM_REQ-1, not a power-of-2 overflow.
- Single-beat packets never enter LOCKED.
- Owner drops valid while LOCKED: the grant is held and no other requester is served. Bubbles pass downstream.
- Output register on accept: out_valid_o←1, and out_data_o/out_last_o/out_src_o load from w.
- Output register with no accept and out_ready_i=1: out_valid_o←0; data/last/src hold their last value.
- Output register with out_valid_o=1 and out_ready_i=0: all output fields are stable.
- No requests: nothing is accepted, and rr_ptr and state are unchanged.
- Reset values (immediate on reset_n low, at any time including mid-packet): state=IDLE, owner=0, rr_ptr=0, out_valid_o=0, out_data_o=0, out_last_o=0, out_src_o=0, busy_o=0, req_ready_o=0.
- A partially forwarded packet is discarded by reset. Requesters are responsible for restarting it.

## Timing
- req_ready_o is combinational from req_valid_i, out_ready_i and registered state. No path from req_data_i/req_last_i to any ready.
- Latency: a beat accepted at edge N appears on out_valid_o/out_data_o after edge N.
- Throughput: 1 beat/cycle sustained while out_ready_i=1.
- Arbitration switch costs 0 cycles: the beat after a last can come from a different requester in the next cycle.
- rr_ptr and state updates take effect for the arbitration decision in the cycle after the accepting edge.

## Test plan
- Reset: reset_n=0 with random inputs -> all outputs 0, req_ready_o=0. After release with no valids -> out_valid_o stays 0.
- All four requesters valid with single-beat packets, out_ready_i=1 -> one beat per cycle, out_src_o sequence 0,1,2,3,0,1; never two ready bits set.
- Requester 1 sends a 3-beat packet while requester 0 is valid -> out_src_o=1,1,1 with last on beat 3, then 0; busy_o high exactly while beats 1–2 are outstanding.
- out_ready_i held low 3 cycles with out_valid_o=1 -> out_data_o/out_src_o unchanged, req_ready_o=0; the first beat is released the cycle out_ready_i rises.
- Requester 2 drops valid for 2 cycles mid-packet while requester 3 is valid -> out_valid_o=0 during the gap, no beat from 3 until 2's last is accepted; then 3 is served (rr_ptr=3).
- reset_n pulsed low while LOCKED on requester 1 -> busy_o=0 and out_valid_o=0 immediately, rr_ptr=0. Afterwards requesters 1 and 3 valid -> requester 1 wins first.
